branch_resolve: RTL

- Back-end partner of the dual-issue fetch stage's always-taken branch prediction.
- Records every branch that fetch redirected as taken, in an in-order queue (target and fall-through address).
- Matches each record against the actual outcome resolved in EX.
- On a misprediction, drives the fetch correction pair (correct_en, correction) and a pipeline flush, then masks wrong-path traffic for a fixed number of cycles.

---
 rtl/branch_resolve_pkg.sv | 28 ++
 rtl/branch_queue.sv | 72 +++++++
 rtl/branch_resolve.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_pkg
// Purpose  : Shared types and constants for the branch resolution block:
//            default address width, FSM state encoding and the layout of
//            one in-flight branch record.
// Revision : 1.0  initial release
// ============================================================================
package branch_resolve_pkg;

  // Instruction address width (10-bit PC).
  localparam int AW = 10;

  // Recovery FSM encoding.
  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_t;

  // One branch record: predicted target in the upper half, not-taken
  // (fall-through) address in the lower half, 2*AW bits in total.
  typedef struct packed {
    logic [AW-1:0] target;
    logic [AW-1:0] fallthru;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/branch_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_queue
// Purpose  : In-order circular buffer of predicted-taken branch records.
//            Pointers wrap modulo DEPTH; a separate occupancy count drives
//            full/empty. clear empties the queue on the next edge and takes
//            priority over push/pop.
// Ports    : clk, rst (async, active-low)
//            push/din  - write din at the tail
//            pop       - retire the head entry
//            clear     - discard all entries
//            dout      - current head entry
//            full, empty
// Revision : 1.0  initial release
// ============================================================================
module branch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]       r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_CNT_W'(DEPTH));
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve
// Purpose  : Tracks branches that fetch redirected as taken, checks each one
//            against the outcome resolved in EX and, on a misprediction,
//            issues a one-cycle fetch correction plus pipeline flush, then
//            ignores wrong-path push/resolve traffic for RECOVER_CYCLES.
// Ports    : clk, rst (async, active-low)
//            hold, push_valid, push_target, push_fallthru   - from fetch
//            res_valid, res_taken, res_target               - from EX
//            correct_en, correction, flush                  - to fetch/pipe
//            busy, full, empty, overflow, underflow,
//            mispredict_cnt                                 - status
// Revision : 1.0  initial release
// ============================================================================
module branch_resolve #(
  parameter int DEPTH          = 4,
  parameter int AW             = branch_resolve_pkg::AW,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          push_valid,
  input  logic [AW-1:0] push_target,
  input  logic [AW-1:0] push_fallthru,
  input  logic          res_valid,
  input  logic          res_taken,
  input  logic [AW-1:0] res_target,
  output logic          correct_en,
  output logic [AW-1:0] correction,
  output logic          flush,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow,
  output logic [15:0]   mispredict_cnt
);

  import branch_resolve_pkg::*;

  localparam int c_RC_W = $clog2(RECOVER_CYCLES + 1);

  state_t              r_state, w_state_nxt;
  logic [c_RC_W-1:0]   r_rc_cnt, w_rc_cnt_nxt;
  logic                r_correct_en;
  logic [AW-1:0]       r_correction;
  logic                r_overflow;
  logic                r_underflow;
  logic [15:0]         r_mcnt;

  logic [2*AW-1:0]     w_head;
  logic [AW-1:0]       w_head_target;
  logic [AW-1:0]       w_head_fallthru;
  logic                w_idle;
  logic                w_pop;
  logic                w_mispredict;
  logic [AW-1:0]       w_corr_val;
  logic                w_push_req;
  logic                w_push;

  // Record layout follows entry_t: {target, fallthru}.
  assign w_head_target   = w_head[2*AW-1:AW];
  assign w_head_fallthru = w_head[AW-1:0];

  assign w_idle       = (r_state == IDLE);
  assign w_pop        = res_valid && w_idle && !empty;
  assign w_mispredict = w_pop && (!res_taken || (res_target != w_head_target));
  assign w_corr_val   = res_taken ? res_target : w_head_fallthru;

  // A push that coincides with a mispredict is wrong-path: drop it silently.
  assign w_push_req   = push_valid && !hold && w_idle && !w_mispredict;
  // A simultaneous pop frees a slot, so a full queue still accepts the push.
  assign w_push       = w_push_req && (!full || w_pop);

  branch_queue #(
    .DEPTH (DEPTH),
    .W     (2*AW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (w_mispredict),
    .din   ({push_target, push_fallthru}),
    .dout  (w_head),
    .full  (full),
    .empty (empty)
  );

  // Recovery FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rc_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rc_cnt <= w_rc_cnt_nxt;
    end
  end

  // Recovery FSM: next state. The counter is loaded with RECOVER_CYCLES and
  // leaving on a value of 1 makes RECOVER last exactly that many cycles.
  always_comb begin
    w_state_nxt  = r_state;
    w_rc_cnt_nxt = r_rc_cnt;
    case (r_state)
      IDLE: begin
        if (w_mispredict) begin
          w_state_nxt  = RECOVER;
          w_rc_cnt_nxt = c_RC_W'(RECOVER_CYCLES);
        end
      end
      RECOVER: begin
        if (r_rc_cnt == c_RC_W'(1)) begin
          w_state_nxt = IDLE;
        end
        w_rc_cnt_nxt = r_rc_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Correction pulse, sticky flags and saturating mispredict counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_correct_en <= 1'b0;
      r_correction <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_mcnt       <= '0;
    end else begin
      r_correct_en <= w_mispredict;
      if (w_mispredict) begin
        r_correction <= w_corr_val;
        if (r_mcnt != 16'hFFFF) r_mcnt <= r_mcnt + 16'd1;
      end
      if (w_push_req && full && !w_pop) r_overflow <= 1'b1;
      if (res_valid && w_idle && empty) r_underflow <= 1'b1;
    end
  end

  assign correct_en     = r_correct_en;
  assign flush          = r_correct_en;
  assign correction     = r_correction;
  assign busy           = (r_state == RECOVER);
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;
  assign mispredict_cnt = r_mcnt;

endmodule
`default_nettype wire
